// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: single-bus CPU datapath with a sequenced ALU.
//
// Holds the GPR file, HI/LO/PC/MDR/MAR/IR/InPort/OutPort, the Y operand
// register and a 2*WIDTH Z result register. All of them share one bus,
// driven from an encoded source select. The ALU runs logic, arithmetic,
// shift and rotate ops in a single cycle. Signed MUL and DIV iterate over
// WIDTH edges using a start/busy/done handshake.
//
// Ports:
//   clock, clear        clock; synchronous active-low reset
//   src_sel             bus source (GPRs, then HI, LO, ZHI, ZLO, PC, MDR,
//                       InPort, C); any other value drives 0
//   gpr_in, *_in        load enables from the bus
//   mdr_read, mdata_in  MDR loads memory data instead of the bus
//   inport_data         sampled into InPort every cycle
//   alu_op, alu_start   ALU request; operands are A=Y and B=bus
//   bus_out             current bus value
//   mar_out, ir_out, mdata_out, outport_data, z_hi, z_lo   register contents
//   busy, done, div_by_zero   ALU status
module bus_datapath_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_GPR = 16,
    parameter int unsigned IMM_W   = 19,
    parameter int unsigned SEL_W   = 5
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [SEL_W-1:0]   src_sel,
    input  logic [NUM_GPR-1:0] gpr_in,
    input  logic               hi_in,
    input  logic               lo_in,
    input  logic               pc_in,
    input  logic               mar_in,
    input  logic               ir_in,
    input  logic               y_in,
    input  logic               outport_in,
    input  logic               mdr_in,
    input  logic               mdr_read,
    input  logic [WIDTH-1:0]   mdata_in,
    input  logic [WIDTH-1:0]   inport_data,
    input  logic [3:0]         alu_op,
    input  logic               alu_start,
    output logic [WIDTH-1:0]   bus_out,
    output logic [WIDTH-1:0]   mar_out,
    output logic [WIDTH-1:0]   ir_out,
    output logic [WIDTH-1:0]   mdata_out,
    output logic [WIDTH-1:0]   outport_data,
    output logic [WIDTH-1:0]   z_hi,
    output logic [WIDTH-1:0]   z_lo,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [SEL_W-1:0] SRC_HI  = SEL_W'(NUM_GPR + 0);
    localparam logic [SEL_W-1:0] SRC_LO  = SEL_W'(NUM_GPR + 1);
    localparam logic [SEL_W-1:0] SRC_ZHI = SEL_W'(NUM_GPR + 2);
    localparam logic [SEL_W-1:0] SRC_ZLO = SEL_W'(NUM_GPR + 3);
    localparam logic [SEL_W-1:0] SRC_PC  = SEL_W'(NUM_GPR + 4);
    localparam logic [SEL_W-1:0] SRC_MDR = SEL_W'(NUM_GPR + 5);
    localparam logic [SEL_W-1:0] SRC_IN  = SEL_W'(NUM_GPR + 6);
    localparam logic [SEL_W-1:0] SRC_C   = SEL_W'(NUM_GPR + 7);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
        OP_ROL, OP_NEG, OP_NOT, OP_MUL, OP_DIV, OP_INC, OP_RSV0, OP_RSV1
    } op_e;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

    logic [WIDTH-1:0] gpr [NUM_GPR];
    logic [WIDTH-1:0] hi, lo, pc, mdr, mar, ir, inport, outport, y;
    logic [WIDTH-1:0] c_src;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mq, m, a_keep;
    logic             is_div, a_neg, b_neg, b_zero;

    op_e              op;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] alu_res, a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, mul_sel, rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign c_src        = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign mar_out      = mar;
    assign ir_out       = ir;
    assign mdata_out    = mdr;
    assign outport_data = outport;

    always_comb begin
        bus_out = '0;
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            if (src_sel == SEL_W'(i)) bus_out = gpr[i];
        end
        case (src_sel)
            SRC_HI:  bus_out = hi;
            SRC_LO:  bus_out = lo;
            SRC_ZHI: bus_out = z_hi;
            SRC_ZLO: bus_out = z_lo;
            SRC_PC:  bus_out = pc;
            SRC_MDR: bus_out = mdr;
            SRC_IN:  bus_out = inport;
            SRC_C:   bus_out = c_src;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            hi      <= '0;
            lo      <= '0;
            pc      <= '0;
            mdr     <= '0;
            mar     <= '0;
            ir      <= '0;
            inport  <= '0;
            outport <= '0;
            y       <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_GPR; i++) begin
                if (gpr_in[i]) gpr[i] <= bus_out;
            end
            if (hi_in)      hi      <= bus_out;
            if (lo_in)      lo      <= bus_out;
            if (pc_in)      pc      <= bus_out;
            if (mar_in)     mar     <= bus_out;
            if (ir_in)      ir      <= bus_out;
            if (y_in)       y       <= bus_out;
            if (outport_in) outport <= bus_out;
            if (mdr_in)     mdr     <= mdr_read ? mdata_in : bus_out;
            inport <= inport_data;
        end
    end

    // Single-cycle results, with A = Y and B = bus.
    assign op = op_e'(alu_op);
    assign sh = bus_out[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = y + bus_out;
            OP_SUB:  alu_res = y - bus_out;
            OP_AND:  alu_res = y & bus_out;
            OP_OR:   alu_res = y | bus_out;
            OP_SHR:  alu_res = y >> sh;
            OP_SHRA: alu_res = $signed(y) >>> sh;
            OP_SHL:  alu_res = y << sh;
            OP_ROR:  alu_res = WIDTH'({y, y} >> sh);
            OP_ROL:  alu_res = WIDTH'({y, y} >> (WIDTH - sh));
            OP_NEG:  alu_res = '0 - bus_out;
            OP_NOT:  alu_res = ~bus_out;
            OP_INC:  alu_res = bus_out + WIDTH'(1);
            default: alu_res = '0;
        endcase
    end

    assign a_mag = y[WIDTH-1] ? ('0 - y) : y;
    assign b_mag = bus_out[WIDTH-1] ? ('0 - bus_out) : bus_out;

    // MUL: {acc,mq} shifts right, adding the multiplicand when mq[0] is set.
    // DIV: {acc,mq} shifts left, and a restoring subtract sets each quotient bit.
    assign mul_sum  = {1'b0, acc} + {1'b0, m};
    assign mul_sel  = mq[0] ? mul_sum : {1'b0, acc};
    assign rem_sh   = {acc, mq[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, m};
    assign rem_diff = rem_sh[WIDTH-1:0] - m;

    assign prod_fix = (a_neg ^ b_neg) ? ('0 - {acc, mq}) : {acc, mq};
    assign quot_fix = (a_neg ^ b_neg) ? ('0 - mq) : mq;
    assign rem_fix  = a_neg ? ('0 - acc) : acc;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mq          <= '0;
            m           <= '0;
            a_keep      <= '0;
            is_div      <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            b_zero      <= 1'b0;
            z_hi        <= '0;
            z_lo        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (alu_start) begin
                        div_by_zero <= 1'b0;
                        if (op == OP_MUL || op == OP_DIV) begin
                            is_div <= (op == OP_DIV);
                            a_neg  <= y[WIDTH-1];
                            b_neg  <= bus_out[WIDTH-1];
                            b_zero <= (bus_out == '0);
                            a_keep <= y;
                            acc    <= '0;
                            cnt    <= '0;
                            // Divide works on dividend in mq; multiply on multiplier in mq.
                            mq     <= (op == OP_DIV) ? a_mag : b_mag;
                            m      <= (op == OP_DIV) ? b_mag : a_mag;
                            busy   <= 1'b1;
                            state  <= ITER;
                        end else begin
                            z_hi <= '0;
                            z_lo <= alu_res;
                            done <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (is_div) begin
                        acc <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], rem_ge};
                    end else begin
                        acc <= mul_sel[WIDTH:1];
                        mq  <= {mul_sel[0], mq[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        {z_hi, z_lo} <= prod_fix;
                    end else if (b_zero) begin
                        z_hi        <= a_keep;
                        z_lo        <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        z_hi <= rem_fix;
                        z_lo <= quot_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Randomised and directed bench for bus_datapath_seq. A behavioural model
// tracks every register. Each accepted ALU request pushes its expected
// result and completion edge onto a scoreboard, and a monitor pops it
// when done is seen.
module tb_bus_datapath_seq;

    localparam int unsigned W  = 32;
    localparam int unsigned NG = 16;
    localparam int unsigned IW = 19;
    localparam int unsigned SW = 5;
    localparam logic [SW-1:0] S_MDR = 5'd21;
    localparam logic [SW-1:0] S_IN  = 5'd22;

    logic          clock = 1'b0;
    logic          clear;
    logic [SW-1:0] src_sel;
    logic [NG-1:0] gpr_in;
    logic          hi_in, lo_in, pc_in, mar_in, ir_in, y_in, outport_in, mdr_in, mdr_read;
    logic [W-1:0]  mdata_in, inport_data;
    logic [3:0]    alu_op;
    logic          alu_start;
    logic [W-1:0]  bus_out, mar_out, ir_out, mdata_out, outport_data, z_hi, z_lo;
    logic          busy, done, div_by_zero;

    bus_datapath_seq #(.WIDTH(W), .NUM_GPR(NG), .IMM_W(IW), .SEL_W(SW)) dut (
        .clock(clock), .clear(clear), .src_sel(src_sel), .gpr_in(gpr_in),
        .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .mar_in(mar_in), .ir_in(ir_in),
        .y_in(y_in), .outport_in(outport_in), .mdr_in(mdr_in), .mdr_read(mdr_read),
        .mdata_in(mdata_in), .inport_data(inport_data), .alu_op(alu_op),
        .alu_start(alu_start), .bus_out(bus_out), .mar_out(mar_out), .ir_out(ir_out),
        .mdata_out(mdata_out), .outport_data(outport_data), .z_hi(z_hi), .z_lo(z_lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned edge_n = 0;

    typedef struct {
        logic [W-1:0] zh;
        logic [W-1:0] zl;
        logic         dz;
        int unsigned  e;
    } exp_t;
    exp_t scb[$];

    logic [W-1:0] mg [NG];
    logic [W-1:0] mhi, mlo, mpc, mmdr, mmar, mir, min, mout, my, mzh, mzl;
    logic         mdbz;
    logic         pend_v, pend_dz, busy_v;
    logic [W-1:0] pend_zh, pend_zl;
    int unsigned  pend_e, free_e, busy_lo, busy_hi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NG; i++) mg[i] = '0;
        {mhi, mlo, mpc, mmdr, mmar, mir, min, mout, my, mzh, mzl} = '0;
        mdbz = 1'b0;
        pend_v = 1'b0;
        busy_v = 1'b0;
        free_e = 0;
        scb.delete();
    endtask

    function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] zh,
                                    output logic [W-1:0] zl, output logic dz);
        int unsigned sh;
        longint sa, sbv, q, r;
        logic [63:0] pv;
        sh = b % W;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        zh = '0;
        zl = '0;
        dz = 1'b0;
        case (op)
            4'd0:  zl = a + b;
            4'd1:  zl = a - b;
            4'd2:  zl = a & b;
            4'd3:  zl = a | b;
            4'd4:  for (int unsigned i = 0; i < W; i++) zl[i] = (i + sh < W) ? a[i + sh] : 1'b0;
            4'd5:  for (int unsigned i = 0; i < W; i++) zl[i] = (i + sh < W) ? a[i + sh] : a[W-1];
            4'd6:  for (int unsigned i = 0; i < W; i++) zl[i] = (i >= sh) ? a[i - sh] : 1'b0;
            4'd7:  for (int unsigned i = 0; i < W; i++) zl[i] = a[(i + sh) % W];
            4'd8:  for (int unsigned i = 0; i < W; i++) zl[i] = a[(i + W - sh) % W];
            4'd9:  zl = -b;
            4'd10: zl = ~b;
            4'd13: zl = b + 1;
            4'd11: begin
                pv = sa * sbv;
                zh = pv[63:32];
                zl = pv[31:0];
            end
            4'd12: begin
                if (b == '0) begin
                    zl = '1;
                    zh = a;
                    dz = 1'b1;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    zl = W'(q);
                    zh = W'(r);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] m_bus(input logic [SW-1:0] s);
        logic [W-1:0] c;
        c = {{(W-IW){mir[IW-1]}}, mir[IW-1:0]};
        if (s < NG) return mg[s[3:0]];
        case (s)
            5'd16: return mhi;
            5'd17: return mlo;
            5'd18: return mzh;
            5'd19: return mzl;
            5'd20: return mpc;
            5'd21: return mmdr;
            5'd22: return min;
            5'd23: return c;
            default: return '0;
        endcase
    endfunction

    // Drive is already applied; cross one clock edge, advance the model, check outputs.
    task automatic tick();
        logic [W-1:0] mb, rzh, rzl;
        logic rdz;
        mb = m_bus(src_sel);
        #1;
        check("bus_out", bus_out, mb);
        @(posedge clock);
        edge_n++;
        if (!clear) begin
            m_reset();
        end else begin
            if (pend_v && pend_e == edge_n) begin
                mzh = pend_zh;
                mzl = pend_zl;
                mdbz = pend_dz;
                pend_v = 1'b0;
            end
            if (alu_start && edge_n >= free_e) begin
                ref_alu(alu_op, my, mb, rzh, rzl, rdz);
                mdbz = 1'b0;
                if (alu_op == 4'd11 || alu_op == 4'd12) begin
                    pend_v = 1'b1;
                    pend_e = edge_n + W + 1;
                    pend_zh = rzh;
                    pend_zl = rzl;
                    pend_dz = rdz;
                    free_e = edge_n + W + 2;
                    busy_v = 1'b1;
                    busy_lo = edge_n;
                    busy_hi = edge_n + W;
                    scb.push_back('{rzh, rzl, rdz, edge_n + W + 1});
                end else begin
                    mzh = rzh;
                    mzl = rzl;
                    free_e = edge_n + 1;
                    scb.push_back('{rzh, rzl, 1'b0, edge_n});
                end
            end
            for (int i = 0; i < NG; i++) if (gpr_in[i]) mg[i] = mb;
            if (hi_in) mhi = mb;
            if (lo_in) mlo = mb;
            if (pc_in) mpc = mb;
            if (mar_in) mmar = mb;
            if (ir_in) mir = mb;
            if (y_in) my = mb;
            if (outport_in) mout = mb;
            if (mdr_in) mmdr = mdr_read ? mdata_in : mb;
            min = inport_data;
        end
        @(negedge clock);
        check("mar_out", mar_out, mmar);
        check("ir_out", ir_out, mir);
        check("mdata_out", mdata_out, mmdr);
        check("outport_data", outport_data, mout);
        check("z_hi", z_hi, mzh);
        check("z_lo", z_lo, mzl);
        check("div_by_zero", div_by_zero, mdbz);
        check("busy", busy, busy_v && edge_n >= busy_lo && edge_n <= busy_hi);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest accepted request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (scb.size() == 0) begin
                    check("done_spurious", done, 1'b0);
                end else begin
                    e = scb.pop_front();
                    check("done_edge", edge_n, e.e);
                    check("sb_z_hi", z_hi, e.zh);
                    check("sb_z_lo", z_lo, e.zl);
                    check("sb_dbz", div_by_zero, e.dz);
                end
            end else if (scb.size() > 0 && edge_n > scb[0].e) begin
                check("done_missing", done, 1'b1);
                void'(scb.pop_front());
            end
        end
    end

    task automatic idle();
        clear = 1'b1;
        src_sel = '0;
        gpr_in = '0;
        {hi_in, lo_in, pc_in, mar_in, ir_in, y_in, outport_in, mdr_in, mdr_read} = '0;
        mdata_in = '0;
        inport_data = '0;
        alu_op = '0;
        alu_start = 1'b0;
    endtask

    task automatic put_mdr(input logic [W-1:0] v);
        idle();
        mdr_in = 1'b1;
        mdr_read = 1'b1;
        mdata_in = v;
        tick();
    endtask

    task automatic load_y(input logic [W-1:0] v);
        put_mdr(v);
        idle();
        src_sel = S_MDR;
        y_in = 1'b1;
        tick();
    endtask

    task automatic start_op(input logic [3:0] op, input logic [SW-1:0] bsel);
        idle();
        src_sel = bsel;
        alu_op = op;
        alu_start = 1'b1;
        tick();
        idle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle();
        while (scb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        #1;
        check("drain", scb.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_inputs();
        idle();
        src_sel = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
        if ($urandom_range(0, 2) == 0) gpr_in = 16'(1) << $urandom_range(0, 15);
        hi_in = ($urandom_range(0, 5) == 0);
        lo_in = ($urandom_range(0, 5) == 0);
        pc_in = ($urandom_range(0, 5) == 0);
        mar_in = ($urandom_range(0, 3) == 0);
        ir_in = ($urandom_range(0, 4) == 0);
        y_in = ($urandom_range(0, 2) == 0);
        outport_in = ($urandom_range(0, 3) == 0);
        mdr_in = ($urandom_range(0, 2) == 0);
        mdr_read = $urandom_range(0, 1) == 1;
        mdata_in = pick();
        inport_data = pick();
        alu_start = ($urandom_range(0, 3) == 0);
        alu_op = 4'($urandom_range(0, 15));
        clear = !($urandom_range(0, 150) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_reset();
        idle();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        idle();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("rst_z", {z_hi, z_lo}, 64'h0);
        check("rst_mar", mar_out, 0);
        check("rst_mdr", mdata_out, 0);

        // R3 = 7 through the memory path, R4 = 5 through InPort, then ADD.
        put_mdr(32'd7);
        idle(); src_sel = S_MDR; gpr_in = 16'h0008; tick();
        idle(); inport_data = 32'd5; tick();
        idle(); src_sel = S_IN; gpr_in = 16'h0010; tick();
        idle(); src_sel = 5'd3; y_in = 1'b1; tick();
        start_op(4'd0, 5'd4);
        check("add_done_next", done, 1'b1);
        wait_idle();
        check("add_zlo", z_lo, 12);
        check("add_zhi", z_hi, 0);

        // -6 * 7, with exact busy length.
        load_y(32'hFFFF_FFFA);
        put_mdr(32'd7);
        start_op(4'd11, S_MDR);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            idle();
            tick();
        end
        check("mul_busy_cycles", n, W + 1);
        check("mul_done", done, 1'b1);
        check("mul_z", {z_hi, z_lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        wait_idle();

        // -17 / 5 with an ignored start mid-operation.
        load_y(-32'sd17);
        put_mdr(32'd5);
        start_op(4'd12, S_MDR);
        repeat (5) begin idle(); tick(); end
        start_op(4'd0, S_MDR);
        wait_idle();
        check("div_q", z_lo, 32'hFFFF_FFFD);
        check("div_r", z_hi, 32'hFFFF_FFFE);

        // Divide by zero; the unused select 31 drives a zero bus.
        load_y(32'd9);
        start_op(4'd12, 5'd31);
        wait_idle();
        check("dz_flag", div_by_zero, 1'b1);
        check("dz_zlo", z_lo, 32'hFFFF_FFFF);
        check("dz_zhi", z_hi, 32'd9);
        start_op(4'd0, S_MDR);
        check("dz_cleared", div_by_zero, 1'b0);
        wait_idle();

        // Shift and rotate corner patterns.
        load_y(32'h8000_0001);
        put_mdr(32'd1);
        start_op(4'd7, S_MDR); wait_idle();
        check("ror", z_lo, 32'hC000_0000);
        start_op(4'd5, S_MDR); wait_idle();
        check("shra", z_lo, 32'hC000_0000);
        start_op(4'd4, S_MDR); wait_idle();
        check("shr", z_lo, 32'h4000_0000);

        // Most-negative operand cases.
        load_y(32'h8000_0000);
        put_mdr(32'h8000_0000);
        start_op(4'd11, S_MDR); wait_idle();
        check("mul_minmin", {z_hi, z_lo}, 64'h4000_0000_0000_0000);
        put_mdr(32'hFFFF_FFFF);
        start_op(4'd12, S_MDR); wait_idle();
        check("div_min_m1", {z_hi, z_lo}, 64'h0000_0000_8000_0000);

        // Reset during iteration 10 abandons the multiply.
        load_y(32'd3);
        put_mdr(32'd4);
        start_op(4'd11, S_MDR);
        repeat (10) begin idle(); tick(); end
        idle(); clear = 1'b0; tick();
        check("abort_busy", busy, 1'b0);
        check("abort_z", {z_hi, z_lo}, 64'h0);
        check("abort_done", done, 1'b0);
        idle(); repeat (W + 4) tick();
        load_y(32'd3);
        put_mdr(32'd4);
        start_op(4'd11, S_MDR);
        wait_idle();
        check("after_abort_mul", {z_hi, z_lo}, 64'd12);

        // Randomised traffic against the model.
        repeat (500) begin
            rand_inputs();
            tick();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
